// File: rtl/fir_ctrl_pkg.sv
// ============================================================================
// fir_ctrl_pkg : shared types and ring-pointer helpers for the FIR MAC sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } fir_seq_state_t;

    // Explicit compares keep the ring correct for non-power-of-two lengths.
    function automatic int ring_dec(input int v, input int n);
        return (v == 0) ? n - 1 : v - 1;
    endfunction

    function automatic int ring_inc(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// fir_mac_sequencer : time-multiplexes one MAC over all taps of a decimating FIR
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS   = 64,
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 4,
    parameter int ADDR_W     = $clog2(NUM_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  buf_we,
    output logic [ADDR_W-1:0]     buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic [ADDR_W-1:0]     buf_raddr,
    output logic [ADDR_W-1:0]     coef_addr,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int                DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic [DEC_W-1:0]  LAST_DEC = DEC_W'(DECIM - 1);

    fir_seq_state_t    state;
    fir_seq_state_t    state_next;
    logic              live;      // low until the first clock after reset release
    logic [ADDR_W-1:0] k;         // tap index in RUN, clear address in CLEAR
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;    // newest - k, walked backward around the ring
    logic [DEC_W-1:0]  dec_cnt;
    logic              accept;

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (live && (k == LAST_TAP)) state_next = IDLE;
            IDLE:    if (accept && (dec_cnt == LAST_DEC)) state_next = RUN;
            RUN:     if (k == LAST_TAP) state_next = DRAIN;
            DRAIN:   state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = live && (state != IDLE);
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = '0;
        buf_raddr = '0;
        coef_addr = '0;
        res_valid = 1'b0;
        case (state)
            CLEAR: begin
                buf_we    = live;
                buf_waddr = k;
            end
            IDLE: begin
                if (accept) begin
                    buf_we    = 1'b1;
                    buf_waddr = wr_ptr;
                    buf_wdata = in_data;
                end
            end
            RUN: begin
                buf_raddr = rd_ptr;
                coef_addr = k;
            end
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // Pointers, counters and the one-cycle strobe delay that matches memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            k       <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dec_cnt <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
        end else begin
            live    <= 1'b1;
            mac_en  <= (state == RUN);
            mac_clr <= (state == RUN) && (k == '0);
            case (state)
                CLEAR: begin
                    if (live) k <= (k == LAST_TAP) ? '0 : k + 1'b1;
                end
                IDLE: begin
                    if (accept) begin
                        wr_ptr  <= ADDR_W'(ring_inc(32'(wr_ptr), NUM_TAPS));
                        rd_ptr  <= wr_ptr;
                        k       <= '0;
                        dec_cnt <= (dec_cnt == LAST_DEC) ? '0 : dec_cnt + 1'b1;
                    end
                end
                RUN: begin
                    rd_ptr <= ADDR_W'(ring_dec(32'(rd_ptr), NUM_TAPS));
                    k      <= (k == LAST_TAP) ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control sequencer that time-multiplexes a single multiply-accumulate unit over all taps of the decimating FIR filter in the sigma-delta decimation chain. It accepts input samples over a ready/valid handshake, writes them into an external circular sample RAM, and, every DECIM-th sample, walks sample-RAM and coefficient-ROM addresses through NUM_TAPS cycles while driving the MAC's clear and enable strobes. It then presents a result-valid handshake to the downstream stage. The sample RAM, coefficient ROM and MAC/accumulator sit outside this block. Both memories have a 1-cycle synchronous read.

## Interface
- NUM_TAPS, 64, filter length; any value ≥ 2, not necessarily a power of two
- DATA_WIDTH, 16, sample width (s1.15)
- DECIM, 4, decimation factor; ≥ 1
- ADDR_W, $clog2(NUM_TAPS), derived address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_WIDTH  upstream sample
- buf_we  out  1  sample-RAM write enable
- buf_waddr  out  ADDR_W  sample-RAM write address
- buf_wdata  out  DATA_WIDTH  sample-RAM write data
- buf_raddr  out  ADDR_W  sample-RAM read address
- coef_addr  out  ADDR_W  coefficient-ROM read address
- mac_en  out  1  MAC consumes the current memory outputs
- mac_clr  out  1  with mac_en: accumulator loads the product instead of adding it
- res_valid  out  1  accumulator holds a finished output
- res_ready  in  1  downstream accepts the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states are CLEAR, IDLE, RUN, DRAIN and RESULT. Reset enters CLEAR.
- **CLEAR:** buf_we=1, buf_wdata=0, buf_waddr counts 0..NUM_TAPS-1 with one write per cycle, then the FSM goes to IDLE. in_ready=0 throughout.
- **IDLE:** in_ready=1. On in_valid&&in_ready, combinationally in the same cycle: buf_we=1, buf_waddr=wr_ptr, buf_wdata=in_data.
  - Then newest←wr_ptr and wr_ptr←(wr_ptr+1) mod NUM_TAPS.
  - If dec_cnt==DECIM-1: dec_cnt←0, k←0, and the FSM goes to RUN. Otherwise dec_cnt++ and the FSM stays in IDLE.
- **RUN:** in_ready=0. Per cycle, issue coef_addr=k and buf_raddr=(newest−k) mod NUM_TAPS.
  - The read pointer steps backward; it wraps from 0 to NUM_TAPS-1 by explicit compare, not by bit truncation.
  - After the cycle that issues k=NUM_TAPS-1, the FSM goes to DRAIN.
- **mac_en / mac_clr:** mac_en is the issue strobe registered by one cycle, matching the memory latency. mac_clr is the registered copy of (k==0 issue).
- **DRAIN:** one cycle in which the last mac_en fires, then the FSM goes to RESULT.
- **RESULT:** res_valid=1, held until res_ready is sampled high. Then res_valid drops and the FSM returns to IDLE. The accumulator must not be touched while in RESULT.
- **Backpressure:** in_valid outside IDLE stalls upstream; samples are never dropped or overwritten.
- **Reset values:**
  - All outputs 0, except that CLEAR drives buf_we=1 from the first clock after reset release.
  - wr_ptr=0, dec_cnt=0, k=0.
  - Reset asserted mid-RUN or mid-RESULT aborts immediately: the pending result is discarded and CLEAR reruns.

## Timing
- A sample accepted at cycle T that triggers a computation produces:
  - RUN in cycles T+1..T+NUM_TAPS
  - mac_en in cycles T+2..T+NUM_TAPS+1, with mac_clr at T+2 only
  - DRAIN at T+NUM_TAPS+1
  - res_valid from T+NUM_TAPS+2
- With res_ready tied high, the next in_ready is at T+NUM_TAPS+3.
- The first read in RUN (T+1) returns the sample written at T. No same-cycle read/write collision on the same address ever occurs.
- CLEAR lasts exactly NUM_TAPS cycles, so the first in_ready rises NUM_TAPS cycles after reset release.
- With DECIM=1, every accepted sample triggers RUN.

## Structure
- Package fir_ctrl_pkg holds:
  - the state enum fir_seq_state_t {CLEAR, IDLE, RUN, DRAIN, RESULT}
  - the wrap-decrement and wrap-increment functions for a NUM_TAPS ring
- No sub-module: the FSM, pointers and the 1-cycle strobe delay stage all live in fir_mac_sequencer.
- The memories and MAC are instantiated alongside this block by the filter top level.

## Test plan
- **Reset/CLEAR:** release reset, NUM_TAPS=64 → buf_we high for 64 cycles with waddr 0..63 and wdata 0; in_ready first rises in cycle 64.
- **Single output, DECIM=1:** accept sample 0x4000 at T → RUN T+1..T+64 with raddr 0,63,62,…,1 and coef_addr 0..63; mac_clr only at T+2; res_valid at T+66.
- **Decimation, DECIM=4:** stream 4 samples back-to-back → no RUN after samples 1–3; RUN starts the cycle after the 4th sample with raddr beginning at 3.
- **Wrap-around, NUM_TAPS=5:** push 7 samples with DECIM=1 → 7th write goes to addr 1; its RUN reads 1,0,4,3,2.
- **Result backpressure:** hold res_ready low for 10 cycles with in_valid high → res_valid stays high, in_ready stays 0, no mac_en; on res_ready, IDLE follows and the next sample is accepted.
- **Reset mid-RUN:** assert rst_n low at k=30 → all outputs 0 immediately; after release, CLEAR runs again and no res_valid appears for the aborted sample.
